// File: rtl/auth_resp_arbiter.sv
// Round-robin arbiter sharing one authentication responder between NUM_REQ requesters.
// Optional per-requester timeout statistics are enabled with `define AUTH_ARB_STATS_EN.
module auth_resp_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int MSG_W      = 512,
  parameter int CNT_W      = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*MSG_W-1:0] req_msg_i,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic [NUM_REQ-1:0]       timeout_o,
  output logic                     busy_o,
  output logic                     resp_req_o,
  output logic [MSG_W-1:0]         resp_msg_o,
  output logic                     resp_ack_o,
  input  logic                     resp_done_i,
  input  logic [CNT_W-1:0]         resp_timeout_i,
  output logic [NUM_REQ*16-1:0]    timeout_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT, S_ACK, S_GAP} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d, ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d, done_q, done_d, tmo_q, tmo_d;
  logic                 req_q, req_d, ack_q, ack_d, busy_q, busy_d;
  logic [MSG_W-1:0]     msg_q, msg_d;
  logic                 found;
  logic [IDX_W-1:0]     sel, cand;

  // First pending requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    grant_d = grant_q;
    done_d  = '0;
    tmo_d   = '0;
    req_d   = req_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          owner_d = sel;
          grant_d = NUM_REQ'(1) << sel;
          busy_d  = 1'b1;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        // A response beats a timeout detected in the same cycle
        if (resp_done_i) begin
          ack_d   = 1'b1;
          done_d  = grant_q;
          state_d = S_ACK;
        end else if ((cnt_q >= resp_timeout_i) && (cnt_q != '0)) begin
          tmo_d   = grant_q;
          req_d   = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (!req_valid_i[owner_q]) begin
          req_d   = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_ACK: begin
        req_d   = 1'b0;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = IDX_W'((int'(owner_q) + 1) % NUM_REQ);
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    msg_d = (state_d == S_IDLE) ? '0 : req_msg_i[int'(owner_d)*MSG_W +: MSG_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      msg_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      msg_q   <= msg_d;
    end
  end

  assign grant_o    = grant_q;
  assign done_o     = done_q;
  assign timeout_o  = tmo_q;
  assign busy_o     = busy_q;
  assign resp_req_o = req_q;
  assign resp_ack_o = ack_q;
  assign resp_msg_o = msg_q;

`ifdef AUTH_ARB_STATS_EN
  // Counts advance on the same edge that raises the timeout pulse
  for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
    logic [15:0] tcnt_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        tcnt_q <= '0;
      end else if (tmo_d[r] && (tcnt_q != 16'hFFFF)) begin
        tcnt_q <= tcnt_q + 16'd1;
      end
    end
    assign timeout_count_o[r*16 +: 16] = tcnt_q;
  end
`else
  assign timeout_count_o = '0;
`endif

endmodule

// File: tb/tb_auth_resp_arbiter.sv
// Randomized bench for auth_resp_arbiter against a transaction-level reference model,
// with a directed prologue of hand-computed expectations.
module tb_auth_resp_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int MSG_W      = 512;
  localparam int CNT_W      = 32;
  localparam int GAP_CYCLES = 2;
  localparam int VW         = NUM_REQ * MSG_W;
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [VW-1:0]         req_msg = '0;
  logic [NUM_REQ-1:0]    grant_o, done_o, timeout_o;
  logic                  busy_o, resp_req_o, resp_ack_o;
  logic [MSG_W-1:0]      resp_msg_o;
  logic                  resp_done = 1'b0;
  logic [CNT_W-1:0]      resp_timeout = 100;
  logic [NUM_REQ*16-1:0] timeout_count_o;

  always #5 clk = ~clk;

  auth_resp_arbiter #(
    .NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .CNT_W(CNT_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_msg_i(req_msg),
    .grant_o(grant_o), .done_o(done_o), .timeout_o(timeout_o),
    .busy_o(busy_o), .resp_req_o(resp_req_o), .resp_msg_o(resp_msg_o),
    .resp_ack_o(resp_ack_o), .resp_done_i(resp_done),
    .resp_timeout_i(resp_timeout), .timeout_count_o(timeout_count_o)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chkm(string name, logic [MSG_W-1:0] act, logic [MSG_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit vbit(logic [NUM_REQ-1:0] v, int i);
    return bit'(v >> i);
  endfunction

  function automatic logic [MSG_W-1:0] msg_of(int r);
    return MSG_W'(req_msg >> (r * MSG_W));
  endfunction

  task automatic set_msg(int r, logic [MSG_W-1:0] m);
    logic [VW-1:0] mask;
    mask    = VW'({MSG_W{1'b1}}) << (r * MSG_W);
    req_msg = (req_msg & ~mask) | (VW'(m) << (r * MSG_W));
  endtask

  function automatic logic [MSG_W-1:0] rand_msg();
    logic [MSG_W-1:0] m = '0;
    for (int w = 0; w < MSG_W / 32; w++) m = {m[MSG_W-33:0], 32'($urandom)};
    return m;
  endfunction

  // Reference model: expected outputs after each rising edge
  logic [NUM_REQ-1:0] e_grant, e_done, e_tmo;
  logic               e_busy, e_req, e_ack;
  logic [MSG_W-1:0]   e_msg;
  int                 ptr_m, owner_m;
  longint             cnt_m;
  int                 tc_m [NUM_REQ];

  function automatic logic [NUM_REQ*16-1:0] exp_tcnt();
    logic [NUM_REQ*16-1:0] v = '0;
`ifdef AUTH_ARB_STATS_EN
    for (int r = 0; r < NUM_REQ; r++) v = v | ((NUM_REQ*16)'(tc_m[r]) << (16 * r));
`endif
    return v;
  endfunction

  task automatic model_clear();
    e_grant = '0; e_done = '0; e_tmo = '0;
    e_busy = 1'b0; e_req = 1'b0; e_ack = 1'b0; e_msg = '0;
    ptr_m = 0;
    for (int r = 0; r < NUM_REQ; r++) tc_m[r] = 0;
  endtask

  task automatic tick(output bit rs);
    @(posedge clk);
    rs = reset;
    if (rs) model_clear();
  endtask

  task automatic run_txn();
    bit rs;
    owner_m = -1;
    for (int k = 0; k < NUM_REQ; k++)
      if (owner_m < 0 && vbit(req_valid, (ptr_m + k) % NUM_REQ)) owner_m = (ptr_m + k) % NUM_REQ;
    e_grant = NUM_REQ'(1) << owner_m;
    e_busy  = 1'b1;
    e_msg   = msg_of(owner_m);
    tick(rs); if (rs) return;
    e_req = 1'b1;
    e_msg = msg_of(owner_m);
    cnt_m = 0;
    forever begin
      tick(rs); if (rs) return;
      e_msg = msg_of(owner_m);
      if (resp_done) begin
        e_ack  = 1'b1;
        e_done = e_grant;
        tick(rs); if (rs) return;
        e_ack = 1'b0; e_done = '0; e_req = 1'b0;
        e_msg = msg_of(owner_m);
        break;
      end else if (cnt_m >= longint'(resp_timeout) && cnt_m != 0) begin
        e_tmo = e_grant;
        e_req = 1'b0;
        if (tc_m[owner_m] < 65535) tc_m[owner_m]++;
        break;
      end else if (!vbit(req_valid, owner_m)) begin
        e_req = 1'b0;
        break;
      end
      if (cnt_m < CNT_MAX) cnt_m++;
    end
    for (int g = 1; g <= GAP_CYCLES; g++) begin
      tick(rs); if (rs) return;
      e_tmo = '0;
      if (g == GAP_CYCLES) begin
        e_grant = '0; e_busy = 1'b0; e_msg = '0;
        ptr_m = (owner_m + 1) % NUM_REQ;
      end else begin
        e_msg = msg_of(owner_m);
      end
    end
  endtask

  initial begin : model
    bit rs;
    model_clear();
    forever begin
      tick(rs);
      if (!rs && req_valid != '0) run_txn();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", 64'(grant_o), 64'(e_grant));
      chk("done", 64'(done_o), 64'(e_done));
      chk("timeout", 64'(timeout_o), 64'(e_tmo));
      chk("busy", 64'(busy_o), 64'(e_busy));
      chk("resp_req", 64'(resp_req_o), 64'(e_req));
      chk("resp_ack", 64'(resp_ack_o), 64'(e_ack));
      chkm("resp_msg", resp_msg_o, e_msg);
      chk("tcount", 64'(timeout_count_o), 64'(exp_tcnt()));
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [NUM_REQ-1:0] exp_order [3] = '{2'b01, 2'b10, 2'b01};
  logic [MSG_W-1:0]   msg0, msg1;

  initial begin
    int seen;
    logic [NUM_REQ-1:0] prev;
    msg0 = rand_msg();
    msg0[MSG_W-1 -: 16] = 16'h0183;
    msg1 = rand_msg();
    repeat (3) cyc();
    chk_en = 1'b1;
    chk("rst_grant", 64'(grant_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chkm("rst_msg", resp_msg_o, '0);

    // Single request answered after 5 cycles
    reset = 1'b0;
    set_msg(0, msg0);
    req_valid = 2'b01;
    cyc(); chk("t1_grant", 64'(grant_o), 64'(2'b01)); chk("t1_req_early", 64'(resp_req_o), 64'(0));
    cyc(); chk("t1_req", 64'(resp_req_o), 64'(1)); chkm("t1_msg", resp_msg_o, msg0);
    repeat (4) cyc();
    resp_done = 1'b1;
    cyc(); chk("t1_ack", 64'(resp_ack_o), 64'(1)); chk("t1_done", 64'(done_o), 64'(2'b01));
    resp_done = 1'b0; req_valid = '0;
    cyc(); chk("t1_gap1_req", 64'(resp_req_o), 64'(0)); chk("t1_gap1_grant", 64'(grant_o), 64'(2'b01));
    cyc(); chk("t1_gap2_req", 64'(resp_req_o), 64'(0));
    cyc(); chk("t1_release", 64'(grant_o), 64'(0));

    // Timeout on requester 1 with current_timeout = 10
    resp_timeout = 10;
    set_msg(1, msg1);
    req_valid = 2'b10;
    cyc(); chk("t2_grant", 64'(grant_o), 64'(2'b10));
    repeat (11) cyc();
    chk("t2_no_early_tmo", 64'(timeout_o), 64'(0));
    cyc(); chk("t2_tmo", 64'(timeout_o), 64'(2'b10)); chk("t2_req_low", 64'(resp_req_o), 64'(0));
`ifdef AUTH_ARB_STATS_EN
    chk("t2_tcount", 64'(timeout_count_o[31:16]), 64'(1));
`else
    chk("t2_tcount", 64'(timeout_count_o), 64'(0));
`endif
    req_valid = '0;
    cyc(); chk("t2_tmo_clear", 64'(timeout_o), 64'(0));
    cyc(); chk("t2_release", 64'(grant_o), 64'(0));

    // Response and timeout threshold in the same cycle
    resp_timeout = 3;
    req_valid = 2'b01;
    cyc(); chk("t3_grant", 64'(grant_o), 64'(2'b01));
    repeat (4) cyc();
    resp_done = 1'b1;
    cyc(); chk("t3_ack", 64'(resp_ack_o), 64'(1)); chk("t3_done", 64'(done_o), 64'(2'b01));
    chk("t3_no_tmo", 64'(timeout_o), 64'(0));
    resp_done = 1'b0; req_valid = '0;
    cyc(); chk("t3_no_tmo_late", 64'(timeout_o), 64'(0));
    cyc(); cyc(); chk("t3_release", 64'(grant_o), 64'(0));

    // Owner aborts, pending requester granted afterwards
    resp_timeout = 100;
    req_valid = 2'b11;
    cyc(); chk("t4_grant", 64'(grant_o), 64'(2'b10));
    cyc(); chk("t4_req", 64'(resp_req_o), 64'(1));
    cyc(); req_valid = 2'b01;
    cyc(); chk("t4_abort_req", 64'(resp_req_o), 64'(0));
    chk("t4_abort_pulses", 64'({done_o, timeout_o}), 64'(0));
    cyc(); chk("t4_gap_grant", 64'(grant_o), 64'(2'b10));
    cyc(); chk("t4_idle_grant", 64'(grant_o), 64'(0));
    cyc(); chk("t4_next_grant", 64'(grant_o), 64'(2'b01));

    // Reset while waiting for the responder
    cyc(); cyc();
    reset = 1'b1;
    cyc(); chk("t5_req", 64'(resp_req_o), 64'(0)); chk("t5_grant", 64'(grant_o), 64'(0));
    chk("t5_busy", 64'(busy_o), 64'(0));

    // Both requesting from reset, responder always ready
    req_valid = 2'b11; resp_done = 1'b1; reset = 1'b0;
    seen = 0; prev = '0;
    for (int c = 0; c < 80 && seen < 3; c++) begin
      cyc();
      if (grant_o != '0 && prev == '0) begin
        chk($sformatf("rr_order%0d", seen), 64'(grant_o), 64'(exp_order[seen]));
        seen++;
      end
      prev = grant_o;
    end
    chk("rr_count", 64'(seen), 64'(3));
    req_valid = '0; resp_done = 1'b0;
    repeat (10) cyc();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cyc();
      reset = ($urandom_range(0, 399) == 0);
      resp_done = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) resp_timeout = CNT_W'($urandom_range(0, 14));
      for (int r = 0; r < NUM_REQ; r++) begin
        if (!vbit(req_valid, r)) begin
          if ($urandom_range(0, 3) == 0) begin
            set_msg(r, rand_msg());
            req_valid = req_valid | (NUM_REQ'(1) << r);
          end
        end else if (vbit(done_o, r) || vbit(timeout_o, r)) begin
          if ($urandom_range(0, 1) == 0) req_valid = req_valid & ~(NUM_REQ'(1) << r);
        end else if ($urandom_range(0, 63) == 0) begin
          req_valid = req_valid & ~(NUM_REQ'(1) << r);
        end
      end
    end
    cyc();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
